// File: rtl/button_debounce_in_pkg.sv
// button_debounce_in_pkg: shared pad-input FSM encoding and default timing constants
package button_debounce_in_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } deb_state_t;
  localparam int DEF_DEB_CYCLES  = 120000;
  localparam int DEF_LONG_CYCLES = 12000000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-stage synchronizer with configurable reset level
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk)
    if (rst) {q, s1} <= {2{RST_VAL}};
    else     {q, s1} <= {s1, d};
endmodule

// File: rtl/button_debounce_in.sv
// button_debounce_in: debounces a raw push-button pad into a level plus press/release/long pulses
module button_debounce_in
  import button_debounce_in_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pad,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES) begin : g_bad_params
    $error("button_debounce_in: need DEB_CYCLES >= 2 and LONG_CYCLES > DEB_CYCLES");
  end
  deb_state_t state_q, state_d;
  logic [DW-1:0] deb_q, deb_d, deb_inc;
  logic [LW-1:0] long_q, long_d;
  logic synced, raw_p, deb_done, long_run, press_d, rel_d, lp_d;
  sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_pad),
    .q  (synced)
  );
  assign raw_p   = synced ^ ACTIVE_LOW;
  assign pressed = state_q[1];
  always_comb begin
    state_d  = state_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    deb_inc  = (deb_q == DW'(DEB_CYCLES - 1)) ? deb_q : deb_q + 1'b1;
    deb_done = deb_inc == DW'(DEB_CYCLES - 1);
    long_run = state_q == HELD || state_q == REL_WAIT;
    long_d   = (long_run && long_q != LW'(LONG_CYCLES)) ? long_q + 1'b1 : long_q;
    lp_d     = long_run && long_q == LW'(LONG_CYCLES - 1);
    case (state_q)
      IDLE:       state_d = raw_p ? PRESS_WAIT : IDLE;
      PRESS_WAIT: begin
        if (!raw_p) state_d = IDLE;
        else if (deb_done) begin
          state_d = HELD;
          press_d = 1'b1;
          long_d  = '0;
        end
      end
      HELD:       state_d = raw_p ? HELD : REL_WAIT;
      REL_WAIT: begin
        if (raw_p) state_d = HELD;
        else if (deb_done) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          lp_d    = 1'b0;
        end
      end
      default:    state_d = IDLE;
    endcase
    // only the two wait states debounce; any state change restarts the count
    deb_d = (state_d != state_q || !state_q[0]) ? '0 : deb_inc;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q       <= IDLE;
      deb_q         <= '0;
      long_q        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state_q       <= state_d;
      deb_q         <= deb_d;
      long_q        <= long_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
      long_pulse    <= lp_d;
    end
endmodule

// File: tb/tb_button_debounce_in.sv
// tb_button_debounce_in: scoreboard bench for button_debounce_in (active-low and active-high builds)
module tb_button_debounce_in;
  localparam int DEB = 4, LONG = 16;
  localparam logic [2:0] EV_PRESS = 3'b100, EV_REL = 3'b010, EV_LONG = 3'b001;
  typedef struct {int cyc; int who; logic [2:0] kind;} ev_t;
  logic clk = 1'b0, rst = 1'b1, pad = 1'b1, pad_h = 1'b0;
  logic pr, pp, rp, lp, pr_h, pp_h, rp_h, lp_h;
  logic [2:0] ev;
  ev_t x;
  ev_t sb[$];
  int cyc = 0, checks = 0, failures = 0, t = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  button_debounce_in #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .btn_pad(pad), .pressed(pr),
    .press_pulse(pp), .release_pulse(rp), .long_pulse(lp)
  );
  button_debounce_in #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .btn_pad(pad_h), .pressed(pr_h),
    .press_pulse(pp_h), .release_pulse(rp_h), .long_pulse(lp_h)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_ev(input int c, input int w, input logic [2:0] k);
    sb.push_back('{c, w, k});
  endtask
  always @(negedge clk)
    for (int w = 0; w < 2; w++) begin
      ev = w == 0 ? {pp, rp, lp} : {pp_h, rp_h, lp_h};
      if ((|ev) === 1'b1) begin
        chk("onehot", $countones(ev), 1);
        if (sb.size() == 0) chk("unexpected_ev", {w[3:0], 1'b0, ev}, 0);
        else begin
          x = sb.pop_front();
          chk("ev_who", w, x.who);
          chk("ev_kind", ev, x.kind);
          chk("ev_cyc", cyc, x.cyc);
        end
      end
    end
  initial begin
    step(3);
    chk("rst_pressed", pr, 0);
    chk("rst_press_pulse", pp, 0);
    chk("rst_release_pulse", rp, 0);
    chk("rst_long_pulse", lp, 0);
    chk("rst_pressed_h", pr_h, 0);
    rst = 1'b0;
    step(2);
    // clean press held past the long threshold, then clean release
    t = cyc; pad = 1'b0;
    expect_ev(t + 6, 0, EV_PRESS);
    expect_ev(t + 22, 0, EV_LONG);
    step(5); chk("c1_pressed_early", pr, 0);
    step(1); chk("c1_pressed", pr, 1); chk("c1_press_pulse", pp, 1);
    step(1); chk("c1_pulse_width", pp, 0);
    step(29);
    t = cyc; pad = 1'b1;
    expect_ev(t + 6, 0, EV_REL);
    step(5); chk("c3_pressed_before_rel", pr, 1);
    step(1); chk("c3_released", pr, 0); chk("c3_release_pulse", rp, 1);
    step(6);
    // bounce shorter than the debounce window
    pad = 1'b0; step(3);
    pad = 1'b1; step(1);
    chk("c2_mid_bounce", pr, 0);
    pad = 1'b0; step(3);
    pad = 1'b1; step(6);
    chk("c2_after_bounce", pr, 0);
    // release glitch while held
    t = cyc; pad = 1'b0;
    expect_ev(t + 6, 0, EV_PRESS);
    expect_ev(t + 22, 0, EV_LONG);
    step(10);
    pad = 1'b1; step(2);
    pad = 1'b0; step(3);
    chk("c4_glitch_pressed", pr, 1);
    step(4);
    chk("c4_still_pressed", pr, 1);
    step(21);
    t = cyc; pad = 1'b1;
    expect_ev(t + 6, 0, EV_REL);
    step(12);
    // reset pulse mid-hold with button still down
    t = cyc; pad = 1'b0;
    expect_ev(t + 6, 0, EV_PRESS);
    step(10);
    chk("c5_held", pr, 1);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("c5_rst_pressed", pr, 0);
    chk("c5_rst_press_pulse", pp, 0);
    chk("c5_rst_release_pulse", rp, 0);
    chk("c5_rst_long_pulse", lp, 0);
    expect_ev(t + 17, 0, EV_PRESS);
    expect_ev(t + 33, 0, EV_LONG);
    step(7);
    chk("c5_repressed", pr, 1);
    step(22);
    t = cyc; pad = 1'b1;
    expect_ev(t + 6, 0, EV_REL);
    step(12);
    // active-high build
    t = cyc; pad_h = 1'b1;
    expect_ev(t + 6, 1, EV_PRESS);
    step(5); chk("c6_pressed_early", pr_h, 0);
    step(1); chk("c6_pressed", pr_h, 1); chk("c6_press_pulse", pp_h, 1);
    step(4);
    pad_h = 1'b0;
    expect_ev(t + 16, 1, EV_REL);
    step(7);
    chk("c6_released", pr_h, 0);
    step(5);
    chk("sb_empty", sb.size(), 0);
    chk("idle_pressed", pr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
